// File: rtl/riscv_pkg.sv
// Shared core definitions: base address width, arbiter state encoding and
// fetch-side command constants.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam int          FETCH_WIDTH = 32;
    localparam logic [3:0]  FETCH_BE    = 4'hF;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic {
        ARB_FETCH = 1'b0,
        ARB_LOAD  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter between instruction fetch and the program
// loader. Fetch has priority; a starvation counter forces a loader grant.
module imem_arbiter
    import riscv_pkg::*;
#(
    parameter int MaxWait = 8,
    parameter int AddrW   = XLEN
) (
    input  logic             clk_i,
    input  logic             rstn_i,

    input  logic             f_req_i,
    input  logic [AddrW-1:0] f_addr_i,
    input  logic             f_flush_i,
    output logic             f_gnt_o,
    output logic             f_rvalid_o,
    output logic [31:0]      f_rdata_o,

    input  logic             l_req_i,
    input  logic             l_we_i,
    input  logic             l_lock_i,
    input  logic [AddrW-1:0] l_addr_i,
    input  logic [31:0]      l_wdata_i,
    input  logic [3:0]       l_be_i,
    output logic             l_gnt_o,
    output logic             l_rvalid_o,
    output logic [31:0]      l_rdata_o,

    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_gnt_i,
    input  logic [31:0]      mem_rdata_i
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MaxWait);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       owner_q, owner_d;   // 1 = loader owns the outstanding read
    logic       starved;
    logic       sel_f, sel_l;

    always_comb begin
        sel_f       = 1'b0;
        sel_l       = 1'b0;
        starved     = l_req_i && (cnt_q >= MAX_WAIT_C);
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;

        // Nothing is presented while reset is held.
        if (rstn_i) begin
            if (state_q == ARB_FETCH) begin
                if (f_req_i && !starved) begin
                    sel_f = 1'b1;
                end else if (l_req_i) begin
                    sel_l = 1'b1;
                end
            end else begin
                sel_l = l_req_i;
            end
        end

        f_gnt_o = sel_f && mem_gnt_i;
        l_gnt_o = sel_l && mem_gnt_i;

        if (sel_f) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b0;
            mem_addr_o  = f_addr_i;
            mem_wdata_o = '0;
            mem_be_o    = FETCH_BE;
        end else if (sel_l) begin
            mem_req_o   = 1'b1;
            mem_we_o    = l_we_i;
            mem_addr_o  = l_addr_i;
            mem_wdata_o = l_wdata_i;
            mem_be_o    = l_be_i;
        end

        case (state_q)
            ARB_FETCH: if (l_gnt_o && l_lock_i) state_d = ARB_LOAD;
            ARB_LOAD:  if (!l_lock_i || !l_req_i) state_d = ARB_FETCH;
            default:   state_d = ARB_FETCH;
        endcase

        if (l_gnt_o || !l_req_i) begin
            cnt_d = '0;
        end else if (cnt_q < MAX_WAIT_C) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // A fetch flushed in its own grant cycle never becomes pending.
        pend_d  = (f_gnt_o && !f_flush_i) || (l_gnt_o && !l_we_i);
        owner_d = l_gnt_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ARB_FETCH;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
        end
    end

    assign f_rvalid_o = rstn_i && pend_q && !owner_q && !f_flush_i;
    assign l_rvalid_o = rstn_i && pend_q && owner_q;
    assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : 32'h0;
    assign l_rdata_o  = l_rvalid_o ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: priority, starvation, locked bursts,
// flush suppression, stall hold and reset behaviour.
module tb_imem_arbiter;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        f_req_i, f_flush_i;
    logic [31:0] f_addr_i;
    logic        f_gnt_o, f_rvalid_o;
    logic [31:0] f_rdata_o;
    logic        l_req_i, l_we_i, l_lock_i;
    logic [31:0] l_addr_i, l_wdata_i;
    logic [3:0]  l_be_i;
    logic        l_gnt_o, l_rvalid_o;
    logic [31:0] l_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    imem_arbiter #(.MaxWait(8), .AddrW(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_flush_i(f_flush_i),
        .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
        .l_req_i(l_req_i), .l_we_i(l_we_i), .l_lock_i(l_lock_i),
        .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i), .l_be_i(l_be_i),
        .l_gnt_o(l_gnt_o), .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sample;
        @(negedge clk_i);
    endtask

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        f_req_i   = 1'b0;
        f_flush_i = 1'b0;
        l_req_i   = 1'b0;
        l_lock_i  = 1'b0;
        l_we_i    = 1'b0;
    endtask

    initial begin
        rstn_i      = 1'b0;
        f_req_i     = 1'b1;
        f_addr_i    = 32'h8000_0000;
        f_flush_i   = 1'b0;
        l_req_i     = 1'b1;
        l_we_i      = 1'b0;
        l_lock_i    = 1'b0;
        l_addr_i    = 32'h8000_0100;
        l_wdata_i   = 32'h0;
        l_be_i      = 4'hF;
        mem_gnt_i   = 1'b1;
        mem_rdata_i = 32'h0;

        // reset: requests present but nothing granted
        next_cycle();
        sample();
        check_val("rst_f_gnt", {31'b0, f_gnt_o}, 32'd0);
        check_val("rst_l_gnt", {31'b0, l_gnt_o}, 32'd0);
        check_val("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check_val("rst_rvalid", {30'b0, f_rvalid_o, l_rvalid_o}, 32'd0);
        next_cycle();

        // streaming fetch
        rstn_i  = 1'b1;
        l_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_addr_i    = 32'h8000_0000 + 32'(4 * i);
            mem_rdata_i = 32'h1000_0000 + 32'(i);
            sample();
            check_val("fetch_gnt", {31'b0, f_gnt_o}, 32'd1);
            check_val("fetch_addr", mem_addr_o, 32'h8000_0000 + 32'(4 * i));
            check_val("fetch_cmd", {27'b0, mem_we_o, mem_be_o}, 32'h0000_000F);
            check_val("fetch_rvalid", {31'b0, f_rvalid_o}, (i == 0) ? 32'd0 : 32'd1);
            if (i != 0) check_val("fetch_rdata", f_rdata_o, 32'h1000_0000 + 32'(i));
            check_val("fetch_l_rdata", l_rdata_o, 32'h0);
            next_cycle();
        end
        f_req_i     = 1'b0;
        mem_rdata_i = 32'h1234_5678;
        sample();
        check_val("fetch_last_rdata", f_rdata_o, 32'h1234_5678);
        next_cycle();

        // memory stall: command held for 3 cycles, granted on the 4th
        f_req_i  = 1'b1;
        f_addr_i = 32'h8000_0004;
        for (int i = 0; i < 4; i++) begin
            mem_gnt_i = (i == 3);
            sample();
            check_val("stall_gnt", {31'b0, f_gnt_o}, (i == 3) ? 32'd1 : 32'd0);
            check_val("stall_req", {31'b0, mem_req_o}, 32'd1);
            check_val("stall_addr", mem_addr_o, 32'h8000_0004);
            check_val("stall_rvalid", {31'b0, f_rvalid_o}, 32'd0);
            next_cycle();
        end
        f_req_i     = 1'b0;
        mem_rdata_i = 32'hA5A5_0004;
        sample();
        check_val("stall_resp", f_rdata_o, 32'hA5A5_0004);
        next_cycle();

        // flush in the cycle after grant
        f_req_i = 1'b1;
        sample();
        check_val("flush_a_gnt", {31'b0, f_gnt_o}, 32'd1);
        next_cycle();
        f_req_i   = 1'b0;
        f_flush_i = 1'b1;
        mem_rdata_i = 32'hBAD0_0001;
        sample();
        check_val("flush_next_rvalid", {31'b0, f_rvalid_o}, 32'd0);
        check_val("flush_next_rdata", f_rdata_o, 32'h0);
        next_cycle();

        // flush in the grant cycle itself
        f_req_i   = 1'b1;
        f_flush_i = 1'b1;
        sample();
        check_val("flush_same_gnt", {31'b0, f_gnt_o}, 32'd1);
        next_cycle();
        f_req_i   = 1'b0;
        f_flush_i = 1'b0;
        sample();
        check_val("flush_same_rvalid", {31'b0, f_rvalid_o}, 32'd0);
        next_cycle();

        // flush leaves loader reads alone
        l_req_i = 1'b1;
        sample();
        check_val("lflush_gnt", {31'b0, l_gnt_o}, 32'd1);
        next_cycle();
        l_req_i     = 1'b0;
        f_flush_i   = 1'b1;
        mem_rdata_i = 32'h5EED_0001;
        sample();
        check_val("lflush_rvalid", {31'b0, l_rvalid_o}, 32'd1);
        check_val("lflush_rdata", l_rdata_o, 32'h5EED_0001);
        next_cycle();
        f_flush_i = 1'b0;

        // starvation: loader granted in the 9th and 18th contended cycles
        f_req_i = 1'b1;
        l_req_i = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            mem_rdata_i = 32'hCAFE_0000 + 32'(i);
            sample();
            check_val("starve_l_gnt", {31'b0, l_gnt_o}, (i == 9 || i == 18) ? 32'd1 : 32'd0);
            check_val("starve_f_gnt", {31'b0, f_gnt_o}, (i == 9 || i == 18) ? 32'd0 : 32'd1);
            check_val("starve_f_rvalid", {31'b0, f_rvalid_o}, (i == 1 || i == 10) ? 32'd0 : 32'd1);
            check_val("starve_l_rvalid", {31'b0, l_rvalid_o}, (i == 10) ? 32'd1 : 32'd0);
            if (i == 9) check_val("starve_l_addr", mem_addr_o, 32'h8000_0100);
            if (i == 10) check_val("starve_l_rdata", l_rdata_o, 32'hCAFE_000A);
            next_cycle();
        end
        idle_inputs();
        sample();
        check_val("starve_last_l_rvalid", {31'b0, l_rvalid_o}, 32'd1);
        next_cycle();

        // locked 4-beat loader write burst
        l_req_i   = 1'b1;
        l_we_i    = 1'b1;
        l_lock_i  = 1'b1;
        l_addr_i  = 32'h8000_0010;
        l_wdata_i = 32'hDEAD_BEEF;
        l_be_i    = 4'hF;
        for (int i = 0; i < 4; i++) begin
            f_req_i = (i != 0);
            sample();
            check_val("burst_l_gnt", {31'b0, l_gnt_o}, 32'd1);
            check_val("burst_f_gnt", {31'b0, f_gnt_o}, 32'd0);
            check_val("burst_cmd", {27'b0, mem_we_o, mem_be_o}, 32'h0000_001F);
            check_val("burst_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            check_val("burst_rvalid", {30'b0, f_rvalid_o, l_rvalid_o}, 32'd0);
            next_cycle();
        end
        l_req_i  = 1'b0;
        l_lock_i = 1'b0;
        l_we_i   = 1'b0;
        sample();
        check_val("burst_end_gnt", {30'b0, f_gnt_o, l_gnt_o}, 32'd0);
        check_val("burst_end_rvalid", {30'b0, f_rvalid_o, l_rvalid_o}, 32'd0);
        next_cycle();
        sample();
        check_val("burst_resume_f_gnt", {31'b0, f_gnt_o}, 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();

        // reset right after a locked loader read grant
        l_req_i  = 1'b1;
        l_lock_i = 1'b1;
        l_addr_i = 32'h8000_0200;
        sample();
        check_val("rstrd_l_gnt", {31'b0, l_gnt_o}, 32'd1);
        next_cycle();
        rstn_i      = 1'b0;
        mem_rdata_i = 32'hBAD0_0002;
        sample();
        check_val("rstrd_l_rvalid", {31'b0, l_rvalid_o}, 32'd0);
        check_val("rstrd_gnt", {30'b0, f_gnt_o, l_gnt_o}, 32'd0);
        next_cycle();
        rstn_i   = 1'b1;
        f_req_i  = 1'b1;
        l_lock_i = 1'b0;
        sample();
        check_val("rstrd_after_rvalid", {31'b0, l_rvalid_o}, 32'd0);
        check_val("rstrd_fetch_state", {30'b0, f_gnt_o, l_gnt_o}, 32'd2);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
